// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and helpers for the interrupt sequencer:
//   irq_state_e    - sequencer state (IDLE, REQ, HANDLER)
//   MCAUSE_INT_BIT - mcause bit flagging an interrupt (as opposed to exception)
//   irq_make_cause - builds the mcause word for a given source index
// -----------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } irq_state_e;

  localparam int MCAUSE_INT_BIT = 31;

  // Exception code is base + index; the interrupt flag is forced on top.
  function automatic logic [31:0] irq_make_cause(input logic [31:0] base,
                                                 input logic [31:0] idx);
    logic [31:0] code;
    code                 = base + idx;
    code[MCAUSE_INT_BIT] = 1'b1;
    return code;
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-wins priority encoder.
// Ports:
//   req   in  NUM_SRC  request vector
//   valid out 1        at least one request bit set
//   idx   out IDX_W    index of the lowest set request bit (0 when none)
// -----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the top down so the last hit, i.e. the lowest index, sticks.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IDX_W'(i);
      end else begin
        valid = valid;
        idx   = idx;
      end
    end
  end

endmodule

// File: rtl/irq_sequencer.sv
// -----------------------------------------------------------------------------
// irq_sequencer
// Interrupt controller in front of the machine-mode CSR file. Latches the
// interrupt lines into pending bits, masks them with mie / mstatus.MIE, picks
// the lowest-index eligible source and sequences trap entry with a req/ack
// handshake. No further trap is requested until the handler's mret retires.
//
// Optional feature: define IRQ_SYNC_EN to pass every irq bit through a
// 2-flop synchronizer before sampling (adds two cycles of latency).
//
// Ports:
//   clk          in   1        clock, rising edge
//   reset        in   1        asynchronous active-low reset
//   irq_i        in   NUM_SRC  raw interrupt request lines
//   mie_i        in   NUM_SRC  per-source enable mask
//   gie_i        in   1        global enable (mstatus.MIE)
//   clr_i        in   NUM_SRC  software clear of pending bits
//   trap_ack_i   in   1        pipeline has redirected to the handler
//   mret_i       in   1        mret retired
//   trap_req_o   out  1        request to take an interrupt
//   cause_o      out  32       mcause value
//   pending_o    out  NUM_SRC  pending vector for mip readback
//   in_handler_o out  1        high from acceptance until mret
// -----------------------------------------------------------------------------
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned CAUSE_BASE = 11,
  parameter int unsigned EDGE_MODE  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_i,
  input  logic [NUM_SRC-1:0] mie_i,
  input  logic               gie_i,
  input  logic [NUM_SRC-1:0] clr_i,
  input  logic               trap_ack_i,
  input  logic               mret_i,
  output logic               trap_req_o,
  output logic [31:0]        cause_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               in_handler_o
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] hist_r;
  logic [NUM_SRC-1:0] pending_r;
  logic [NUM_SRC-1:0] pend_next_s;
  logic [NUM_SRC-1:0] accept_mask_s;
  logic [NUM_SRC-1:0] eligible_s;
  logic               enc_valid_s;
  logic [IDX_W-1:0]   enc_idx_s;
  irq_state_e         state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [31:0]        cause_r;
  logic               trap_req_r;
  logic               in_handler_r;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync1_r;
  logic [NUM_SRC-1:0] sync2_r;

  // Two-flop synchronizer for the asynchronous request lines.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_r <= '0;
      sync2_r <= '0;
    end else begin
      sync1_r <= irq_i;
      sync2_r <= sync1_r;
    end
  end

  assign irq_s = sync2_r;
`else
  assign irq_s = irq_i;
`endif

  // Next pending vector: rising edges set, clears and acceptance reset, and a
  // simultaneous set beats a clear. Level mode just tracks the sampled line.
  always_comb begin
    accept_mask_s = '0;
    if ((state_r == REQ) && trap_ack_i) begin
      accept_mask_s[idx_r] = 1'b1;
    end else begin
      accept_mask_s = '0;
    end
    if (EDGE_MODE != 0) begin
      pend_next_s = (pending_r & ~clr_i & ~accept_mask_s) | (irq_s & ~hist_r);
    end else begin
      pend_next_s = irq_s;
    end
  end

  // Edge-history and pending flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_r    <= '0;
      pending_r <= '0;
    end else begin
      hist_r    <= irq_s;
      pending_r <= pend_next_s;
    end
  end

  assign eligible_s = pending_r & mie_i;

  irq_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req   (eligible_s),
    .valid (enc_valid_s),
    .idx   (enc_idx_s)
  );

  // Trap sequencing FSM. Winner and cause are frozen on entry to REQ so the
  // pipeline sees a stable mcause for the whole handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      cause_r      <= 32'h0000_0000;
      trap_req_r   <= 1'b0;
      in_handler_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (enc_valid_s && gie_i) begin
            state_r    <= REQ;
            idx_r      <= enc_idx_s;
            cause_r    <= irq_make_cause(32'(CAUSE_BASE), 32'(enc_idx_s));
            trap_req_r <= 1'b1;
          end
        end
        REQ: begin
          if (trap_ack_i) begin
            state_r      <= HANDLER;
            trap_req_r   <= 1'b0;
            in_handler_r <= 1'b1;
          end
        end
        HANDLER: begin
          if (mret_i) begin
            state_r      <= IDLE;
            in_handler_r <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          trap_req_r   <= 1'b0;
          in_handler_r <= 1'b0;
        end
      endcase
    end
  end

  assign trap_req_o   = trap_req_r;
  assign cause_o      = cause_r;
  assign pending_o    = pending_r;
  assign in_handler_o = in_handler_r;

endmodule

// File: tb/tb_irq_sequencer.sv
// -----------------------------------------------------------------------------
// tb_irq_sequencer
// Self-checking bench for irq_sequencer (NUM_SRC=4, CAUSE_BASE=11,
// EDGE_MODE=1). A transaction-level model tracks pending bits and the current
// trap phase; a compare process checks every DUT output on each falling edge.
// Directed scenarios pin the model with literal expectations, then a random
// phase exercises the handshake with random irq/mask/clear/ack/mret traffic.
// Honours IRQ_SYNC_EN (adds two cycles of input delay).
// -----------------------------------------------------------------------------
module tb_irq_sequencer;

  localparam int N          = 4;
  localparam int CAUSE_BASE = 11;
  localparam int EDGE_MODE  = 1;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] irq_i = '0;
  logic [N-1:0] mie_i = '0;
  logic         gie_i = 1'b0;
  logic [N-1:0] clr_i = '0;
  logic         trap_ack_i = 1'b0;
  logic         mret_i = 1'b0;
  logic         trap_req_o;
  logic [31:0]  cause_o;
  logic [N-1:0] pending_o;
  logic         in_handler_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  irq_sequencer #(
    .NUM_SRC    (N),
    .CAUSE_BASE (CAUSE_BASE),
    .EDGE_MODE  (EDGE_MODE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .irq_i        (irq_i),
    .mie_i        (mie_i),
    .gie_i        (gie_i),
    .clr_i        (clr_i),
    .trap_ack_i   (trap_ack_i),
    .mret_i       (mret_i),
    .trap_req_o   (trap_req_o),
    .cause_o      (cause_o),
    .pending_o    (pending_o),
    .in_handler_o (in_handler_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // phase: 0 = no trap outstanding, 1 = trap requested, 2 = inside handler
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_prev = '0;
  logic [N-1:0] m_s1 = '0;
  logic [N-1:0] m_s2 = '0;
  int           m_phase = 0;
  int           m_src = 0;
  logic [31:0]  m_cause = 32'h0;

  function automatic logic [N-1:0] model_pending(input logic [N-1:0] cur,
      input logic [N-1:0] samp, input logic [N-1:0] prev,
      input logic [N-1:0] clr, input bit taken, input int src);
    logic [N-1:0] r;
    if (EDGE_MODE == 0) return samp;
    for (int i = 0; i < N; i++) begin
      bit rise, keep;
      rise = samp[i] && !prev[i];
      keep = cur[i] && !clr[i] && !(taken && src == i);
      r[i] = rise || keep;
    end
    return r;
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_sample(input logic [N-1:0] raw,
                                                input logic [N-1:0] s2);
`ifdef IRQ_SYNC_EN
    return s2;
`else
    return raw;
`endif
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_pend  <= '0;
      m_prev  <= '0;
      m_s1    <= '0;
      m_s2    <= '0;
      m_phase <= 0;
      m_src   <= 0;
      m_cause <= 32'h0;
    end else begin
      m_s1   <= irq_i;
      m_s2   <= m_s1;
      m_prev <= model_sample(irq_i, m_s2);
      m_pend <= model_pending(m_pend, model_sample(irq_i, m_s2), m_prev, clr_i,
                              (m_phase == 1) && trap_ack_i, m_src);
      if (m_phase == 0 && gie_i && (m_pend & mie_i) != '0) begin
        m_src   <= lowest(m_pend & mie_i);
        m_cause <= 32'h8000_0000 + 32'(CAUSE_BASE) + 32'(lowest(m_pend & mie_i));
        m_phase <= 1;
      end else if (m_phase == 1 && trap_ack_i) begin
        m_phase <= 2;
      end else if (m_phase == 2 && mret_i) begin
        m_phase <= 0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en && reset === 1'b1) begin
      check("cyc_trap_req", 32'(trap_req_o), 32'(m_phase == 1));
      check("cyc_in_handler", 32'(in_handler_o), 32'(m_phase == 2));
      check("cyc_cause", cause_o, m_cause);
      check("cyc_pending", 32'(pending_o), 32'(m_pend));
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Wait (bounded) for trap_req_o; report cycles elapsed since the stimulus.
  task automatic wait_req(input int start, output int cyc);
    cyc = start;
    while (trap_req_o !== 1'b1 && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    if (trap_req_o !== 1'b1) check("wait_req_timeout", 32'(trap_req_o), 32'd1);
  endtask

  task automatic pulse_irq(input logic [N-1:0] v);
    irq_i = v;
    @(negedge clk);
    irq_i = '0;
  endtask

  task automatic do_ack();
    trap_ack_i = 1'b1;
    @(negedge clk);
    trap_ack_i = 1'b0;
  endtask

  task automatic do_mret();
    mret_i = 1'b1;
    @(negedge clk);
    mret_i = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    reset = 1'b0;
    #23;
    check("reset_trap_req", 32'(trap_req_o), 32'd0);
    check("reset_cause", cause_o, 32'h0);
    check("reset_pending", 32'(pending_o), 32'h0);
    check("reset_in_handler", 32'(in_handler_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    mie_i = 4'hF;
    gie_i = 1'b1;
    cmp_en = 1'b1;
    cycles(2);

    // single source 2, latency and acceptance clearing
    pulse_irq(4'b0100);
    wait_req(1, cyc);
    check("lat_src2", 32'(cyc), 32'(LAT));
    check("cause_src2", cause_o, 32'h8000_000D);
    check("pend_src2_set", 32'(pending_o), 32'h4);
    do_ack();
    check("ack_clears_p2", 32'(pending_o), 32'h0);
    check("ack_in_handler", 32'(in_handler_o), 32'd1);
    check("ack_req_drop", 32'(trap_req_o), 32'd0);
    cycles(2);
    do_mret();
    check("mret_leaves", 32'(in_handler_o), 32'd0);
    cycles(2);

    // two sources together: src1 first, then src3 back-to-back
    pulse_irq(4'b1010);
    wait_req(1, cyc);
    check("cause_src1", cause_o, 32'h8000_000C);
    do_ack();
    check("pend_after_src1", 32'(pending_o), 32'h8);
    cycles(1);
    do_mret();
    check("b2b_idle_no_req", 32'(trap_req_o), 32'd0);
    @(negedge clk);
    check("b2b_req", 32'(trap_req_o), 32'd1);
    check("cause_src3", cause_o, 32'h8000_000E);
    do_ack();
    do_mret();
    cycles(1);

    // global enable gate
    gie_i = 1'b0;
    pulse_irq(4'b0001);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trap_req_o) cyc++;
    end
    check("gie_off_no_req", 32'(cyc), 32'd0);
    check("gie_off_pending", 32'(pending_o), 32'h1);
    gie_i = 1'b1;
    @(negedge clk);
    check("gie_on_req", 32'(trap_req_o), 32'd1);
    check("cause_src0", cause_o, 32'h8000_000B);
    do_ack();

    // new source while in handler waits for mret
    pulse_irq(4'b0001);
    cycles(LAT + 1);
    check("hdl_pend0", 32'(pending_o), 32'h1);
    check("hdl_no_req", 32'(trap_req_o), 32'd0);
    do_mret();
    check("hdl_ret_no_req", 32'(trap_req_o), 32'd0);
    @(negedge clk);
    check("hdl_ret_req", 32'(trap_req_o), 32'd1);
    do_ack();
    do_mret();
    cycles(1);

    // clear vs. set collision on source 3 (masked off so it stays pending)
    mie_i = 4'b0111;
    pulse_irq(4'b1000);
    cycles(LAT + 1);
    check("clr_pre_p3", 32'(pending_o), 32'h8);
    clr_i = 4'b1000;
    irq_i = 4'b1000;
    @(negedge clk);
    clr_i = '0;
    cycles(LAT + 1);
    check("clr_set_wins", 32'(pending_o), 32'h8);
    irq_i = '0;
    cycles(LAT + 1);
    clr_i = 4'b1000;
    @(negedge clk);
    clr_i = '0;
    check("clr_alone", 32'(pending_o), 32'h0);
    mie_i = 4'hF;
    cycles(1);

    // asynchronous reset in the middle of a request
    pulse_irq(4'b0010);
    wait_req(1, cyc);
    #2;
    reset = 1'b0;
    #1;
    check("arst_trap_req", 32'(trap_req_o), 32'd0);
    check("arst_pending", 32'(pending_o), 32'h0);
    check("arst_in_handler", 32'(in_handler_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cycles(3);
    check("arst_no_stale", 32'(trap_req_o), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) irq_i = N'($urandom);
      clr_i      = ($urandom_range(0, 15) == 0) ? N'($urandom) : '0;
      if ($urandom_range(0, 63) == 0) mie_i = N'($urandom);
      if ($urandom_range(0, 31) == 0) gie_i = ($urandom_range(0, 3) != 0);
      trap_ack_i = trap_req_o ? ($urandom_range(0, 2) == 0)
                              : ($urandom_range(0, 9) == 0);
      mret_i     = in_handler_o ? ($urandom_range(0, 3) == 0)
                                : ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    irq_i = '0;
    clr_i = '0;
    trap_ack_i = 1'b0;
    mret_i = 1'b0;
    cycles(2);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
